// File: rtl/hilo_unit.sv
// HI/LO register stage behind the MULTU multiplier. It waits out the multiplier
// latency, then overwrites, accumulates into or subtracts from {hi,lo}.
module hilo_unit #(
    parameter int unsigned MUL_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] wdata,
    input  logic [63:0] prod,
    output logic        op_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Handshake: a request is accepted on a rising edge where op_valid && op_ready;
    // op_ready is low for the whole multiply, and requests seen then are dropped.

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MADDU = 3'b001;
    localparam logic [2:0] OP_MSUBU = 3'b010;
    localparam logic [2:0] OP_MTHI  = 3'b011;
    localparam logic [2:0] OP_MTLO  = 3'b100;
    localparam logic [3:0] LAT      = 4'(MUL_LATENCY);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [2:0]  pend_op, pend_op_n;
    logic [31:0] hi_q, hi_n, lo_q, lo_n;
    logic        done_q, done_n;
    logic [63:0] acc;

    assign acc = {hi_q, lo_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= 4'd0;
            pend_op <= OP_MULTU;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            pend_op <= pend_op_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            done_q  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        pend_op_n = pend_op;
        hi_n      = hi_q;
        lo_n      = lo_q;
        done_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    case (op)
                        OP_MULTU, OP_MADDU, OP_MSUBU: begin
                            state_n   = S_WAIT;
                            cnt_n     = 4'd1;
                            pend_op_n = op;
                        end
                        OP_MTHI: hi_n = wdata;
                        OP_MTLO: lo_n = wdata;
                        default: ;
                    endcase
                end
            end
            S_WAIT: begin
                if (cnt == LAT) begin
                    state_n = S_IDLE;
                    cnt_n   = 4'd0;
                    done_n  = 1'b1;
                    // 64-bit wraparound arithmetic carries/borrows across lo into hi.
                    case (pend_op)
                        OP_MADDU: {hi_n, lo_n} = acc + prod;
                        OP_MSUBU: {hi_n, lo_n} = acc - prod;
                        default:  {hi_n, lo_n} = prod;
                    endcase
                end else begin
                    cnt_n = cnt + 4'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign busy     = (state == S_WAIT);
    assign op_ready = ~busy;
    assign done     = done_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_unit.sv
// Bench for hilo_unit: a latency-1 instance driven from a vector table plus
// hand-written sequences, and a latency-3 instance for the multi-cycle cases.
module tb_hilo_unit;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] wdata;
        logic [63:0] prod;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic        rst1, valid1, ready1, busy1, done1;
    logic [2:0]  op1;
    logic [31:0] wdata1, hi1, lo1;
    logic [63:0] prod1;

    logic        rst3, valid3, ready3, busy3, done3;
    logic [2:0]  op3;
    logic [31:0] wdata3, hi3, lo3;
    logic [63:0] prod3;

    hilo_unit #(.MUL_LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1), .op_valid(valid1), .op(op1), .wdata(wdata1),
        .prod(prod1), .op_ready(ready1), .busy(busy1), .done(done1),
        .hi(hi1), .lo(lo1)
    );

    hilo_unit #(.MUL_LATENCY(3)) dut3 (
        .clk(clk), .reset(rst3), .op_valid(valid3), .op(op3), .wdata(wdata3),
        .prod(prod3), .op_ready(ready3), .busy(busy3), .done(done3),
        .hi(hi3), .lo(lo3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one table entry on the latency-1 instance and check its outcome.
    task automatic run_vec(input int idx, input vec_t v);
        int cycles;
        @(negedge clk);
        valid1 = 1'b1; op1 = v.op; wdata1 = v.wdata; prod1 = v.prod;
        @(posedge clk); #1;
        valid1 = 1'b0;
        if (v.op <= 3'd2) begin
            chk($sformatf("v%0d busy_after_accept", idx), 64'(busy1), 64'd1);
            cycles = 0;
            while (!done1 && cycles < 20) begin
                @(posedge clk); #1;
                cycles++;
            end
            chk($sformatf("v%0d done_seen", idx), 64'(done1), 64'd1);
            chk($sformatf("v%0d busy_cycles", idx), 64'(cycles), 64'd1);
            chk($sformatf("v%0d busy_after_capture", idx), 64'(busy1), 64'd0);
            chk($sformatf("v%0d hi", idx), 64'(hi1), 64'(v.exp_hi));
            chk($sformatf("v%0d lo", idx), 64'(lo1), 64'(v.exp_lo));
            @(posedge clk); #1;
            chk($sformatf("v%0d done_width", idx), 64'(done1), 64'd0);
        end else begin
            chk($sformatf("v%0d busy", idx), 64'(busy1), 64'd0);
            chk($sformatf("v%0d done", idx), 64'(done1), 64'd0);
            chk($sformatf("v%0d hi", idx), 64'(hi1), 64'(v.exp_hi));
            chk($sformatf("v%0d lo", idx), 64'(lo1), 64'(v.exp_lo));
        end
    endtask

    initial begin
        vec_t vecs[10];
        vecs[0] = '{3'b000, 32'h0, 64'hFFFFFFFE_00000001, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{3'b001, 32'h0, 64'h00000000_0000FE01, 32'hFFFFFFFE, 32'h0000FE02};
        vecs[2] = '{3'b010, 32'h0, 64'h00000000_00005500, 32'hFFFFFFFE, 32'h0000A902};
        vecs[3] = '{3'b011, 32'hFFFFFFFF, 64'h0, 32'hFFFFFFFF, 32'h0000A902};
        vecs[4] = '{3'b100, 32'hFFFFFFFF, 64'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[5] = '{3'b001, 32'h0, 64'h1, 32'h00000000, 32'h00000000};
        vecs[6] = '{3'b010, 32'h0, 64'h1, 32'hFFFFFFFF, 32'hFFFFFFFF};
        vecs[7] = '{3'b100, 32'h00000000, 64'h0, 32'hFFFFFFFF, 32'h00000000};
        vecs[8] = '{3'b111, 32'hDEADBEEF, 64'h5, 32'hFFFFFFFF, 32'h00000000};
        vecs[9] = '{3'b000, 32'h0, 64'h00000000_00002490, 32'h00000000, 32'h00002490};

        rst1 = 1'b1; valid1 = 1'b0; op1 = 3'd0; wdata1 = 32'd0; prod1 = 64'd0;
        rst3 = 1'b1; valid3 = 1'b0; op3 = 3'd0; wdata3 = 32'd0; prod3 = 64'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset hi", 64'(hi1), 64'd0);
        chk("reset lo", 64'(lo1), 64'd0);
        chk("reset busy", 64'(busy1), 64'd0);
        chk("reset done", 64'(done1), 64'd0);
        chk("reset op_ready", 64'(ready1), 64'd1);
        chk("reset3 busy", 64'(busy3), 64'd0);
        @(negedge clk);
        rst1 = 1'b0; rst3 = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Request held during WAIT is ignored; re-issued once ready it lands.
        @(negedge clk);
        valid1 = 1'b1; op1 = 3'b000; prod1 = 64'h0;
        @(posedge clk); #1;
        op1 = 3'b011; wdata1 = 32'h12345678;
        chk("busy_req op_ready", 64'(ready1), 64'd0);
        chk("busy_req busy", 64'(busy1), 64'd1);
        @(posedge clk); #1;
        valid1 = 1'b0;
        chk("busy_req done", 64'(done1), 64'd1);
        chk("busy_req hi", 64'(hi1), 64'd0);
        chk("busy_req lo", 64'(lo1), 64'd0);
        @(posedge clk); #1;
        chk("busy_req no_accept hi", 64'(hi1), 64'd0);
        chk("busy_req op_ready_back", 64'(ready1), 64'd1);
        @(negedge clk);
        valid1 = 1'b1; op1 = 3'b011; wdata1 = 32'h12345678;
        @(posedge clk); #1;
        valid1 = 1'b0;
        chk("reissue hi", 64'(hi1), 64'h12345678);
        chk("reissue lo", 64'(lo1), 64'd0);

        // Reset together with a multiply request drops the request.
        @(negedge clk);
        rst1 = 1'b1; valid1 = 1'b1; op1 = 3'b000; prod1 = 64'h77;
        @(posedge clk); #1;
        rst1 = 1'b0; valid1 = 1'b0;
        chk("rst_req busy", 64'(busy1), 64'd0);
        chk("rst_req hi", 64'(hi1), 64'd0);
        @(posedge clk); #1;
        chk("rst_req done", 64'(done1), 64'd0);
        chk("rst_req lo", 64'(lo1), 64'd0);

        // Latency 3: product changes in intermediate cycles must not be used.
        @(negedge clk);
        valid3 = 1'b1; op3 = 3'b000; prod3 = 64'h00000000_00002490;
        @(posedge clk); #1;
        valid3 = 1'b0; prod3 = 64'hDEADBEEF_CAFEF00D;
        chk("lat3 busy1", 64'(busy3), 64'd1);
        @(posedge clk); #1;
        prod3 = 64'h11111111_22222222;
        chk("lat3 busy2", 64'(busy3), 64'd1);
        chk("lat3 no_early_done", 64'(done3), 64'd0);
        @(posedge clk); #1;
        prod3 = 64'h00000000_00002490;
        chk("lat3 busy3", 64'(busy3), 64'd1);
        chk("lat3 hold lo", 64'(lo3), 64'd0);
        @(posedge clk); #1;
        prod3 = 64'hFFFFFFFF_FFFFFFFF;
        chk("lat3 done", 64'(done3), 64'd1);
        chk("lat3 busy_fall", 64'(busy3), 64'd0);
        chk("lat3 hi", 64'(hi3), 64'd0);
        chk("lat3 lo", 64'(lo3), 64'h2490);
        @(posedge clk); #1;
        chk("lat3 done_width", 64'(done3), 64'd0);

        // Reset during WAIT discards the pending capture.
        @(negedge clk);
        valid3 = 1'b1; op3 = 3'b001; prod3 = 64'h00000005_00000005;
        @(posedge clk); #1;
        valid3 = 1'b0;
        chk("rst_wait busy_before", 64'(busy3), 64'd1);
        rst3 = 1'b1;
        @(posedge clk); #1;
        rst3 = 1'b0;
        chk("rst_wait hi", 64'(hi3), 64'd0);
        chk("rst_wait lo", 64'(lo3), 64'd0);
        chk("rst_wait busy", 64'(busy3), 64'd0);
        chk("rst_wait done", 64'(done3), 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk($sformatf("rst_wait no_capture%0d", k), {done3, busy3, hi3, lo3[29:0]}, 64'd0);
        end

        // Reserved op on the latency-3 instance leaves everything alone.
        @(negedge clk);
        valid3 = 1'b1; op3 = 3'b111; wdata3 = 32'hA5A5A5A5;
        @(posedge clk); #1;
        valid3 = 1'b0;
        chk("rsv3 busy", 64'(busy3), 64'd0);
        chk("rsv3 hilo", {hi3, lo3}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- HI/LO register stage directly downstream of the MULTU unsigned 32x32 multiplier.
- Tracks the multiplier's fixed latency after an operation issues, then captures the 64-bit product into HI/LO.
- Captures either by overwrite (MULTU), accumulate (MADDU) or subtract (MSUBU).
- Also services MTHI/MTLO writes and exposes HI/LO to the MFHI/MFLO datapath, with a busy/ready handshake toward the decode stage.

Parameters:
- MUL_LATENCY, 1: clock edges from the operand-presentation edge to a valid z on the MULTU output; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- op_valid  input  1  operation request this cycle
- op  input  3  000 MULTU, 001 MADDU, 010 MSUBU, 011 MTHI, 100 MTLO; 101-111 reserved
- wdata  input  32  source value for MTHI/MTLO
- prod  input  64  z output of the MULTU multiplier (operands are driven to MULTU in the same cycle as op_valid)
- op_ready  output  1  combinational, equals ~busy; request accepted when op_valid && op_ready
- busy  output  1  multiply in flight
- done  output  1  one-cycle pulse after a product capture
- hi  output  32  HI register (MFHI source)
- lo  output  32  LO register (MFLO source)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (reset), sampled only on the rising edge of clk.
- Reset values: hi=0, lo=0, busy=0, done=0, latency counter=0, pending-op register=MULTU.
- States:
  - IDLE (busy=0).
  - WAIT (busy=1, counter counts up to MUL_LATENCY).
- IDLE, accept edge, multiply ops (op_valid=1 and op in {MULTU, MADDU, MSUBU}):
  - Store op and set counter=1.
  - Go to WAIT.
  - hi/lo unchanged.
- WAIT, each edge: if counter==MUL_LATENCY, capture prod and return to IDLE; otherwise counter+1.
  - Example: MUL_LATENCY=1 gives accept at E0, busy high for one cycle, capture at E1.
- Capture arithmetic, modulo 2^64 with carry/borrow between lo and hi and no flags:
  - MULTU: {hi,lo} <= prod.
  - MADDU: {hi,lo} <= {hi,lo} + prod.
  - MSUBU: {hi,lo} <= {hi,lo} - prod.
- done: 1 for exactly the cycle after the capture edge, 0 otherwise.
- MTHI/MTLO in IDLE: hi (or lo) <= wdata at the accept edge; no WAIT, no busy, no done. The other register is untouched.
- Reserved op codes with op_valid=1 in IDLE: no state change, no busy.
- Requests while busy=1 (op_ready=0): ignored and not queued; the requester must hold op_valid until op_ready.
- Back-to-back: a new request may be accepted on the capture edge's following cycle (busy falls after capture). Sustained throughput is 1 multiply per MUL_LATENCY+1 cycles.
- MFHI/MFLO read hi/lo directly.
  - During WAIT, hi/lo hold their pre-operation values.
  - The decode stage must stall reads on busy.
- prod is sampled only at the capture edge; its value in other cycles is don't-care.
- Reset mid-operation: reset overrides every other input on the same edge.
  - WAIT is aborted and the pending capture is discarded.
  - hi/lo=0, busy=0, done=0 on the next cycle.
- Reset asserted together with op_valid: request dropped.

Test Plan:
- MULTU, prod=FFFFFFFF*FFFFFFFF, MUL_LATENCY=1 -> busy high 1 cycle, then hi=FFFFFFFE, lo=00000001, done pulse 1 cycle.
- Follow with MADDU on prod=000000FF*000000FF=0000FE01 -> hi=FFFFFFFE, lo=0000FE02. Then MSUBU on prod=00000080*000000AA=00005500 -> hi=FFFFFFFE, lo=0000A902.
- Wrap: MTHI FFFFFFFF, MTLO FFFFFFFF, then MADDU with prod=1 -> hi=0, lo=0. MSUBU with prod=1 from 0 -> hi=FFFFFFFF, lo=FFFFFFFF.
- MTHI 12345678 issued during WAIT of MULTU 000000B3*0 -> op_ready=0 and the request is ignored; hi=0, lo=0 after capture. Re-issue once op_ready=1 -> hi=12345678.
- MUL_LATENCY=3: MULTU 0000002D*000000D0 -> busy high 3 cycles; capture lo=00002490, hi=0; prod changed in intermediate cycles is not observed.
- Reset asserted in WAIT cycle with hi/lo previously nonzero -> next cycle hi=0, lo=0, busy=0, no done pulse. Reserved op 111 in IDLE -> no change.
